// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receive stage with start-bit glitch rejection and break handling.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop and the o_parity_err output.
module uart_receiver #(
  parameter int BAUD_RATE         = 10000,
  parameter int CLOCK_FREQUENCY   = 250000,
  parameter int CYCLES_PER_SAMPLE = CLOCK_FREQUENCY / BAUD_RATE,
  parameter int HALF_SAMPLE       = CYCLES_PER_SAMPLE / 2
) (
  input  logic       clk,
  input  logic       r_reset,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err,
`ifdef UART_RX_PARITY_EN
  output logic       o_parity_err,
`endif
  output logic       o_busy
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
`ifdef UART_RX_PARITY_EN
    , ST_PARITY
`endif
  } state_t;

  localparam logic [15:0] LP_HALF_M1 = 16'(HALF_SAMPLE - 1);
  localparam logic [15:0] LP_FULL_M1 = 16'(CYCLES_PER_SAMPLE - 1);

  state_t      r_state;
  logic [15:0] r_cnt;
  logic [3:0]  r_bit_idx;
  logic [7:0]  r_shift;
  logic        r_rx_meta;
  logic        r_rx_s;

  state_t      w_state_n;
  logic [15:0] w_cnt_n;
  logic [3:0]  w_bit_idx_n;
  logic [7:0]  w_shift_n;
  logic [7:0]  w_data_n;
  logic        w_valid_n;
  logic        w_frame_err_n;
  logic        w_busy_n;
  logic        w_bit_tick;

`ifdef UART_RX_PARITY_EN
  logic        r_par_bit;
  logic        w_par_bit_n;
  logic        w_parity_err_n;
`endif

  // Two-flop synchroniser; idle-high reset so a reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (r_reset) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= i_rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (r_reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 16'd0;
      r_bit_idx    <= 4'd0;
      r_shift      <= 8'd0;
      o_data       <= 8'd0;
      o_valid      <= 1'b0;
      o_frame_err  <= 1'b0;
      o_busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bit    <= 1'b0;
      o_parity_err <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_n;
      r_cnt        <= w_cnt_n;
      r_bit_idx    <= w_bit_idx_n;
      r_shift      <= w_shift_n;
      o_data       <= w_data_n;
      o_valid      <= w_valid_n;
      o_frame_err  <= w_frame_err_n;
      o_busy       <= w_busy_n;
`ifdef UART_RX_PARITY_EN
      r_par_bit    <= w_par_bit_n;
      o_parity_err <= w_parity_err_n;
`endif
    end
  end

  assign w_bit_tick = (r_cnt == LP_FULL_M1);

  always_comb begin
    w_state_n      = r_state;
    w_cnt_n        = r_cnt;
    w_bit_idx_n    = r_bit_idx;
    w_shift_n      = r_shift;
    w_data_n       = o_data;
    w_valid_n      = 1'b0;
    w_frame_err_n  = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_bit_n    = r_par_bit;
    w_parity_err_n = 1'b0;
`endif

    case (r_state)
      ST_IDLE: begin
        if (!r_rx_s) begin
          w_state_n = ST_START;
          w_cnt_n   = 16'd0;
        end
      end

      ST_START: begin
        if (r_cnt == LP_HALF_M1) begin
          w_cnt_n = 16'd0;
          // A start bit that is gone by its centre was noise on the line.
          if (!r_rx_s) begin
            w_state_n   = ST_DATA;
            w_bit_idx_n = 4'd0;
          end else begin
            w_state_n = ST_IDLE;
          end
        end else begin
          w_cnt_n = r_cnt + 16'd1;
        end
      end

      ST_DATA: begin
        if (w_bit_tick) begin
          w_cnt_n   = 16'd0;
          w_shift_n = {r_rx_s, r_shift[7:1]};
          if (r_bit_idx == 4'd7) begin
            w_bit_idx_n = 4'd0;
`ifdef UART_RX_PARITY_EN
            w_state_n   = ST_PARITY;
`else
            w_state_n   = ST_STOP;
`endif
          end else begin
            w_bit_idx_n = r_bit_idx + 4'd1;
          end
        end else begin
          w_cnt_n = r_cnt + 16'd1;
        end
      end

`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (w_bit_tick) begin
          w_cnt_n     = 16'd0;
          w_par_bit_n = r_rx_s;
          w_state_n   = ST_STOP;
        end else begin
          w_cnt_n = r_cnt + 16'd1;
        end
      end
`endif

      ST_STOP: begin
        if (w_bit_tick) begin
          w_cnt_n = 16'd0;
          if (r_rx_s) begin
            w_data_n  = r_shift;
            w_valid_n = 1'b1;
            w_state_n = ST_IDLE;
`ifdef UART_RX_PARITY_EN
            w_parity_err_n = ^{r_shift, r_par_bit};
`endif
          end else begin
            w_frame_err_n = 1'b1;
            w_state_n     = ST_BREAK;
          end
        end else begin
          w_cnt_n = r_cnt + 16'd1;
        end
      end

      // Hold here while the line stays low so a break yields a single error.
      ST_BREAK: begin
        if (r_rx_s) begin
          w_state_n = ST_IDLE;
        end
      end

      default: begin
        w_state_n = ST_IDLE;
        w_cnt_n   = 16'd0;
      end
    endcase

    w_busy_n = (w_state_n != ST_IDLE);
  end

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - directed bench for uart_receiver with a pulse scoreboard.
module tb_uart_receiver;

  localparam int CPS  = 25;
  localparam int HALF = 12;
`ifdef UART_RX_PARITY_EN
  localparam int LAT  = 2 + HALF + 10 * CPS + 1;
`else
  localparam int LAT  = 2 + HALF + 9 * CPS + 1;
`endif

  logic       clk = 1'b0;
  logic       r_reset;
  logic       i_rx;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_busy;
`ifdef UART_RX_PARITY_EN
  logic       o_parity_err;
`endif

  typedef struct {
    logic       is_err;
    logic [7:0] data;
    logic       par_err;
    int         start;
  } exp_t;

  exp_t       sb[$];
  int         errors  = 0;
  int         checks  = 0;
  int         cyc     = 0;
  int         n_valid = 0;
  int         n_ferr  = 0;
  logic [7:0] last_data;

  uart_receiver dut (
    .clk         (clk),
    .r_reset     (r_reset),
    .i_rx        (i_rx),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_frame_err (o_frame_err),
`ifdef UART_RX_PARITY_EN
    .o_parity_err(o_parity_err),
`endif
    .o_busy      (o_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    i_rx = b;
    repeat (CPS) @(negedge clk);
  endtask

  // Expected pulse is queued at the negedge the start bit is driven.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_flip);
    exp_t e;
    e.start   = cyc;
    e.is_err  = ~stop_bit;
    e.par_err = stop_bit & par_flip;
    if (stop_bit) begin
      e.data    = b;
      last_data = b;
    end else begin
      e.data = last_data;
    end
    sb.push_back(e);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^b) ^ par_flip);
`endif
    send_bit(stop_bit);
  endtask

  always @(negedge clk) begin
    if (r_reset === 1'b0 && (o_valid === 1'b1 || o_frame_err === 1'b1)) begin
      exp_t e;
      if (o_valid === 1'b1) n_valid++;
      if (o_frame_err === 1'b1) n_ferr++;
      check("valid_ferr_exclusive", 32'(o_valid & o_frame_err), 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_pulse", {o_valid, o_frame_err}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("pulse_kind", o_frame_err, e.is_err);
        check("pulse_data", o_data, e.data);
        check("pulse_latency", cyc - e.start, LAT);
`ifdef UART_RX_PARITY_EN
        check("parity_err", o_parity_err, e.par_err);
`endif
      end
    end
  end

  initial begin
    int n;
    r_reset   = 1'b1;
    i_rx      = 1'b1;
    last_data = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_data", o_data, 8'h00);
    check("reset_valid", o_valid, 1'b0);
    check("reset_ferr", o_frame_err, 1'b0);
    check("reset_busy", o_busy, 1'b0);
    r_reset = 1'b0;
    idle(5);

    send_frame(8'hA5, 1'b1, 1'b0);
    idle(2 * CPS);

    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b0);
    idle(2 * CPS);

    i_rx = 1'b0;
    idle(5);
    check("glitch_busy_high", o_busy, 1'b1);
    i_rx = 1'b1;
    n = 0;
    while (o_busy === 1'b1 && n < HALF + 3) begin
      @(negedge clk);
      n++;
    end
    check("glitch_busy_fall", o_busy, 1'b0);
    idle(2 * CPS);

    send_frame(8'h55, 1'b0, 1'b0);
    idle(500);
    check("break_busy", o_busy, 1'b1);
    i_rx = 1'b1;
    idle(2 * CPS);
    check("break_released", o_busy, 1'b0);
    send_frame(8'h81, 1'b1, 1'b0);
    idle(2 * CPS);

    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(((8'hC3 >> i) & 8'h01) != 8'h00);
    i_rx = 1'b0;
    idle(CPS / 2);
    check("midframe_busy", o_busy, 1'b1);
    r_reset = 1'b1;
    @(negedge clk);
    check("midreset_data", o_data, 8'h00);
    check("midreset_valid", o_valid, 1'b0);
    check("midreset_ferr", o_frame_err, 1'b0);
    check("midreset_busy", o_busy, 1'b0);
    r_reset   = 1'b0;
    i_rx      = 1'b1;
    last_data = 8'h00;
    idle(12 * CPS);
    send_frame(8'h12, 1'b1, 1'b0);
    idle(2 * CPS);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0);
    idle(2 * CPS);
    send_frame(8'h07, 1'b1, 1'b1);
    idle(2 * CPS);
`endif

    n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", sb.size(), 32'd0);
`ifdef UART_RX_PARITY_EN
    check("valid_count", n_valid, 32'd8);
`else
    check("valid_count", n_valid, 32'd6);
`endif
    check("ferr_count", n_ferr, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
UART receive stage, the downstream counterpart of the team's UART transmitter. It consumes the serial line driven by the transmitter's o_tx, or by an external pin, and recovers 8N1 frames: start bit, 8 data bits LSB first, stop bit. Each received byte is presented as a one-cycle valid pulse. Malformed frames are flagged with a framing-error pulse. Baud parameters match the transmitter, so the two can be connected back to back for loopback.

Parameters:
BAUD_RATE, 10000, serial bit rate in bits/s
CLOCK_FREQUENCY, 250000, clk frequency in Hz
CYCLES_PER_SAMPLE, CLOCK_FREQUENCY/BAUD_RATE (25), clk cycles per bit; must be >= 4
HALF_SAMPLE, CYCLES_PER_SAMPLE/2 (12), cycles from start detection to start-bit centre check

Ports:
clk  input  1  system clock; all logic on posedge
r_reset  input  1  reset r_reset, synchronous, active-high; clock clk
i_rx  input  1  asynchronous serial line; idle high
o_data  output  8  last received byte; valid while o_valid=1, held until next good frame
o_valid  output  1  one-cycle pulse: o_data updated with a good frame
o_frame_err  output  1  one-cycle pulse: stop bit sampled 0
o_busy  output  1  high in any state other than IDLE

Behaviour:
- Input sync: i_rx passes through 2 flops to give rx_s. Both flops reset to 1. All decisions use rx_s only.
- Registered outputs. Reset values: o_data=0, o_valid=0, o_frame_err=0, o_busy=0. Internal state: state=IDLE, cnt=0, bit_idx=0, shift=0.
- cnt is 16 bits and bit_idx is 4 bits; both are zero-extended for comparisons.
- States are IDLE, START, DATA, STOP, BREAK.
- IDLE:
  - rx_s==0 -> START, cnt=0.
  - Otherwise remain in IDLE.
- START:
  - cnt increments each cycle.
  - When cnt==HALF_SAMPLE-1, sample rx_s.
  - rx_s==0 -> DATA, cnt=0, bit_idx=0.
  - rx_s==1 -> IDLE; this is a glitch rejection, with no output pulse.
- DATA:
  - cnt increments; at cnt==CYCLES_PER_SAMPLE-1, sample rx_s and set cnt=0.
  - shift = {rx_s, shift[7:1]} (LSB first); bit_idx++.
  - After the 8th sample (bit_idx reaches 8) -> STOP, bit_idx=0.
- STOP:
  - Count as in DATA; sample at cnt==CYCLES_PER_SAMPLE-1.
  - rx_s==1: o_data<=shift, o_valid<=1 for exactly the next cycle -> IDLE.
  - rx_s==0: o_frame_err<=1 for one cycle, o_data unchanged -> BREAK.
- BREAK:
  - Wait until rx_s==1, then -> IDLE.
  - A line held low therefore produces one frame error, not repeated frames.
- Latency:
  - The stop sample occurs HALF_SAMPLE + 9*CYCLES_PER_SAMPLE cycles after the IDLE cycle that sees rx_s==0. With defaults that is 237 cycles.
  - o_valid is high on the following cycle.
  - i_rx to rx_s adds 2 cycles.
- Back-to-back frames: IDLE may detect the next start bit on the cycle right after the stop sample; no gap is required.
- o_valid and o_frame_err are never high in the same cycle.
- Reset mid-frame: on the next edge, return to IDLE with all outputs at reset values. The partial byte is discarded with no pulse.
- r_reset has priority over all other transitions.

Optional Feature:
Macro UART_RX_PARITY_EN.
- When defined:
  - A PARITY state sits between DATA and STOP. It samples one even-parity bit at cnt==CYCLES_PER_SAMPLE-1.
  - Adds output o_parity_err (1 bit, reset 0). It pulses together with o_valid when XOR(shift, parity bit)!=0.
  - o_data still updates on a parity error.
  - Frame length grows by CYCLES_PER_SAMPLE.
- When undefined: there is no PARITY state and no o_parity_err port; behaviour is exactly 8N1 as above.

Test Plan:
- Loopback: uart_transmitter o_tx -> i_rx, send 0xA5 -> exactly one o_valid pulse, o_data=0xA5, o_frame_err never high.
- Back-to-back: stream 0x00, 0xFF, 0x3C with minimal idle -> three o_valid pulses with data in order; no frame errors.
- Glitch: drive i_rx low for 5 cycles, then high -> state returns to IDLE; no o_valid, no o_frame_err; o_busy falls within HALF_SAMPLE+3 cycles.
- Framing/break: send 0x55 with stop bit 0, then hold the line low 500 cycles -> one o_frame_err pulse, o_data unchanged; the next good frame 0x81 gives o_valid with o_data=0x81.
- Reset mid-frame: assert r_reset for 1 cycle during DATA bit 4 of 0xC3 -> outputs 0 the next cycle, no pulse for that frame; a following frame 0x12 is received correctly.
- Parity (UART_RX_PARITY_EN): send 0x07 with parity 1 -> o_valid, o_parity_err=0; send 0x07 with parity 0 -> o_valid with o_parity_err=1.
